// File: rtl/tick_controller_if.sv
// Control/status bundle for tick_controller: run control, configuration
// writes and the divided-clock outputs.
interface tick_controller_if #(
  parameter int WIDTH = 25
);
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_half;
  logic             mode_oneshot;
  logic             start;
  logic             stop;
  logic             busy;
  logic             clk_out;
  logic             tick;
  logic             done;

  modport master (
    output cfg_we, cfg_half, mode_oneshot, start, stop,
    input  busy, clk_out, tick, done
  );

  modport slave (
    input  cfg_we, cfg_half, mode_oneshot, start, stop,
    output busy, clk_out, tick, done
  );
endinterface

// File: rtl/tick_controller.sv
// Programmable clock divider with start/stop/one-shot control. Produces a
// 50% square wave, a tick at every toggle and a done pulse for one-shot runs.
module tick_controller #(
  parameter int WIDTH        = 25,
  parameter int DEFAULT_HALF = 25000
) (
  input  logic               C_50Mhz,
  input  logic               rst,
  tick_controller_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] DEF_HALF = WIDTH'(DEFAULT_HALF);

  state_t           state, state_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [WIDTH-1:0] active, active_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] next_cfg;
  logic             oneshot, oneshot_n;
  logic             clk_r, clk_n;
  logic             tick_r, tick_n;
  logic             done_r, done_n;
  logic             busy_r;

  // A programmed half-period of zero behaves as one cycle.
  function automatic logic [WIDTH-1:0] eff_half(input logic [WIDTH-1:0] v);
    return (v == '0) ? WIDTH'(1) : v;
  endfunction

  assign half     = eff_half(active);
  assign next_cfg = bus.cfg_we ? bus.cfg_half : shadow;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    active_n  = active;
    oneshot_n = oneshot;
    clk_n     = clk_r;
    tick_n    = 1'b0;
    done_n    = 1'b0;
    shadow_n  = next_cfg;
    case (state)
      IDLE: begin
        cnt_n = '0;
        clk_n = 1'b1;
        if (bus.start && !bus.stop) begin
          state_n   = RUN;
          active_n  = next_cfg;
          oneshot_n = bus.mode_oneshot;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_n = IDLE;
          cnt_n   = '0;
          clk_n   = 1'b1;
        end else if (cnt == half - WIDTH'(1)) begin
          cnt_n  = '0;
          clk_n  = ~clk_r;
          tick_n = 1'b1;
          // Rising toggle closes a full period: reload or finish here only.
          if (!clk_r) begin
            if (oneshot) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              active_n = next_cfg;
            end
          end
        end else begin
          cnt_n = cnt + WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge C_50Mhz or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shadow  <= DEF_HALF;
      active  <= DEF_HALF;
      oneshot <= 1'b0;
      clk_r   <= 1'b1;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shadow  <= shadow_n;
      active  <= active_n;
      oneshot <= oneshot_n;
      clk_r   <= clk_n;
      tick_r  <= tick_n;
      done_r  <= done_n;
      busy_r  <= (state_n == RUN);
    end
  end

  assign bus.busy    = busy_r;
  assign bus.clk_out = clk_r;
  assign bus.tick    = tick_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_tick_controller.sv
// Scoreboard bench for tick_controller: planned runs push expected tick
// events; a monitor pops and compares whenever the DUT pulses tick or done.
module tb_tick_controller;

  localparam int WIDTH        = 25;
  localparam int DEFAULT_HALF = 25000;

  logic C_50Mhz;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   shadow_model;

  tick_controller_if #(.WIDTH(WIDTH)) bus ();

  tick_controller #(.WIDTH(WIDTH), .DEFAULT_HALF(DEFAULT_HALF)) dut (
    .C_50Mhz (C_50Mhz),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {
    int   at;
    logic clk;
    logic done;
    logic busy;
  } ev_t;

  ev_t exp_q[$];

  initial C_50Mhz = 1'b0;
  always #10 C_50Mhz = ~C_50Mhz;

  initial cyc = 0;
  always @(posedge C_50Mhz) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int hh(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Monitor: every tick/done pulse must match the next expected event.
  always @(negedge C_50Mhz) begin
    if (!rst && (bus.tick || bus.done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got tick=%0b done=%0b at edge %0d, expected none",
                 bus.tick, bus.done, cyc - 1);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("tick_edge", cyc - 1, e.at);
        chk("tick_level", int'(bus.tick), 1);
        chk("clk_out_at_tick", int'(bus.clk_out), int'(e.clk));
        chk("done_at_tick", int'(bus.done), int'(e.done));
        chk("busy_at_tick", int'(bus.busy), int'(e.busy));
      end
    end
  end

  // Plan one run from the current negedge. Edge 0 is the start edge;
  // wr_at/stop_at are edge numbers relative to it (-1 = never).
  task automatic run_plan(input bit use_cfg, input int h0, input bit os,
                          input int wr_at, input int wr_val, input int stop_at);
    int  s, cur, t, last, sh, e;
    bit  stopped, completed;
    ev_t ev;
    s         = cyc;
    sh        = use_cfg ? h0 : shadow_model;
    cur       = hh(sh);
    t         = 0;
    stopped   = 1'b0;
    completed = 1'b0;
    last      = stop_at;
    while (!stopped && !completed && t < 200000) begin
      for (int p = 1; p <= 2; p++) begin
        if (!stopped) begin
          e = t + p * cur;
          if (stop_at >= 0 && e >= stop_at) begin
            stopped = 1'b1;
          end else begin
            ev.at   = s + e;
            ev.clk  = (p == 2);
            ev.done = os && (p == 2);
            ev.busy = !(os && (p == 2));
            exp_q.push_back(ev);
          end
        end
      end
      if (!stopped) begin
        if (os) begin
          completed = 1'b1;
          last      = t + 2 * cur;
        end else begin
          if (wr_at >= 1 && wr_at <= t + 2 * cur) sh = wr_val;
          t   = t + 2 * cur;
          cur = hh(sh);
        end
      end
    end
    for (int k = 0; k <= last; k++) begin
      bus.start        = (k == 0);
      bus.mode_oneshot = os;
      bus.cfg_we       = ((k == 0) && use_cfg) || (k == wr_at);
      bus.cfg_half     = (k == 0) ? WIDTH'(h0) : WIDTH'(wr_val);
      bus.stop         = (k == stop_at);
      @(negedge C_50Mhz);
      if (k == 0) chk("busy_after_start", int'(bus.busy), 1);
    end
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.cfg_we = 1'b0;
    #1;
    chk("busy_after_run", int'(bus.busy), 0);
    chk("clk_out_after_run", int'(bus.clk_out), 1);
    chk("pending_events", exp_q.size(), 0);
    exp_q.delete();
    if (use_cfg) shadow_model = h0;
    if (wr_at >= 1 && wr_at <= last) shadow_model = wr_val;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus.cfg_we       = 1'b0;
    bus.cfg_half     = '0;
    bus.mode_oneshot = 1'b0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    shadow_model     = DEFAULT_HALF;
    repeat (2) @(negedge C_50Mhz);
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_clk_out", int'(bus.clk_out), 1);
    chk("reset_tick", int'(bus.tick), 0);
    chk("reset_done", int'(bus.done), 0);
    @(negedge C_50Mhz);
    rst = 1'b0;
    @(negedge C_50Mhz);

    // Default half-period, periodic, first tick at edge 25000.
    run_plan(1'b0, 0, 1'b0, -1, 0, 25001);
    // One-shot with H=3.
    run_plan(1'b1, 3, 1'b1, -1, 0, -1);
    // Periodic H=4, reprogrammed to 2 mid-period.
    run_plan(1'b1, 4, 1'b0, 2, 2, 13);
    // Periodic H=5 stopped early.
    run_plan(1'b1, 5, 1'b0, -1, 0, 7);

    // start and stop together in IDLE.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge C_50Mhz);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    #1;
    chk("start_stop_idle_busy", int'(bus.busy), 0);
    @(negedge C_50Mhz);
    chk("start_stop_idle_busy2", int'(bus.busy), 0);

    // Zero and one half-periods behave identically.
    run_plan(1'b1, 0, 1'b1, -1, 0, -1);
    run_plan(1'b1, 1, 1'b1, -1, 0, -1);

    for (int i = 0; i < 30; i++) begin
      bit os;
      int h0, wr_at, wr_val, stop_at;
      os     = 1'($urandom_range(0, 1));
      h0     = int'($urandom_range(0, 6));
      wr_at  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 20));
      wr_val = int'($urandom_range(0, 6));
      if (os)
        stop_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * hh(h0))) : -1;
      else
        stop_at = int'($urandom_range(1, 30));
      run_plan(1'b1, h0, os, wr_at, wr_val, stop_at);
      repeat ($urandom_range(0, 3)) @(negedge C_50Mhz);
    end

    // Asynchronous reset in the middle of an H=10 run.
    bus.cfg_we       = 1'b1;
    bus.cfg_half     = WIDTH'(10);
    bus.mode_oneshot = 1'b0;
    bus.start        = 1'b1;
    begin
      ev_t ev;
      ev.at   = cyc + 10;
      ev.clk  = 1'b0;
      ev.done = 1'b0;
      ev.busy = 1'b1;
      exp_q.push_back(ev);
    end
    @(negedge C_50Mhz);
    bus.cfg_we = 1'b0;
    bus.start  = 1'b0;
    repeat (12) @(negedge C_50Mhz);
    chk("pre_reset_events", exp_q.size(), 0);
    @(posedge C_50Mhz);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_clk_out", int'(bus.clk_out), 1);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_tick", int'(bus.tick), 0);
    chk("async_rst_done", int'(bus.done), 0);
    @(negedge C_50Mhz);
    rst          = 1'b0;
    shadow_model = DEFAULT_HALF;
    @(negedge C_50Mhz);
    run_plan(1'b0, 0, 1'b0, -1, 0, 25001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
